digital_input_event_detector: RTL

- Downstream consumer of the 16+16-bit TTL words produced once per sample frame by the digital input deserializer.
- Captures the 32-bit word (expansion word in bits 31:16, main word in bits 15:0) once per frame and debounces each bit over whole samples.
- Detects rising and falling edges on the debounced bits and queues one timestamped event record per frame that has any enabled edge.
- Host/stream logic drains records through a valid/ready handshake.

---
 rtl/digital_input_event_detector_pkg.sv | 29 ++
 rtl/digital_input_event_detector_event_fifo.sv | 68 ++++++
 rtl/digital_input_event_detector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/digital_input_event_detector_pkg.sv
// -----------------------------------------------------------------------------
// digital_input_event_detector_pkg
// Shared constants for the digital input event detector:
//   - frame slot in which the TTL inputs are sampled
//   - event record field widths and their bit offsets in the packed record
//   - helper that maps the debounce setting to an effective threshold
// -----------------------------------------------------------------------------
package digital_input_event_detector_pkg;

  // The deserializer updates its outputs in MS_CLK11_A at channel 16; we sample
  // one slot later so the new word is settled.
  localparam logic [31:0] MS_CLK11_A     = 32'd140;
  localparam logic [5:0]  SAMPLE_CHANNEL = 6'd17;

  // Event record layout: {ts, rise, fall}
  localparam int TS_W     = 32;
  localparam int TTL_W    = 32;
  localparam int REC_W    = TS_W + 2 * TTL_W;
  localparam int FALL_LSB = 0;
  localparam int RISE_LSB = 32;
  localparam int TS_LSB   = 64;

  // A setting of 0 behaves like 1 (accept a change on the first differing
  // sample). Widened to 5 bits so the compare against cnt+1 cannot wrap.
  function automatic logic [4:0] debounce_threshold(input logic [3:0] n);
    return (n == 4'd0) ? 5'd1 : {1'b0, n};
  endfunction

endpackage

// File: rtl/digital_input_event_detector_event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Synchronous FIFO with head-of-queue output (show-ahead).
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i/data_i   write request and data; ignored when full unless popping
//   pop_i           remove head entry; ignored when empty
//   head_o          head entry, forced to 0 while empty
//   count_o         occupancy (0..2^DEPTH_LOG2)
//   full_o/empty_o  status
// Push and pop in the same cycle are both honoured, also when full.
// -----------------------------------------------------------------------------
module event_fifo #(
  parameter int WIDTH      = 96,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // When full, a simultaneous pop frees the slot being written this cycle.
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage has no reset; only the pointers/count define what is valid,
  // so the array maps onto plain RAM/register-file cells without reset muxes.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally modulo DEPTH.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/digital_input_event_detector.sv
// -----------------------------------------------------------------------------
// digital_input_event_detector
// Samples the 32-bit TTL word once per frame, debounces each bit over whole
// samples, detects masked rising/falling edges and queues one timestamped
// record per frame that has any enabled edge.
//   dataclk, reset_n           clock, asynchronous active-low reset
//   main_state, channel        frame position; sampling slot comes from the pkg
//   enable                     detection enable (low: re-prime on next strobe)
//   debounce_samples           samples a new level must persist (0 acts as 1)
//   TTL_parallel(_exp)         main / expansion inputs -> bits 15:0 / 31:16
//   timestamp                  frame timestamp stored with each record
//   rise_mask, fall_mask       per-bit edge enables, captured with the sample
//   clear_overflow             pulse clearing overflow and drop_count
//   ttl_stable                 debounced levels
//   evt_valid/ready            record handshake; evt_* show the head record
//   fifo_count                 FIFO occupancy
//   overflow, drop_count       sticky drop flag, saturating drop counter
// -----------------------------------------------------------------------------
module digital_input_event_detector
  import digital_input_event_detector_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     dataclk,
  input  logic                     reset_n,
  input  logic [31:0]              main_state,
  input  logic [5:0]               channel,
  input  logic                     enable,
  input  logic [3:0]               debounce_samples,
  input  logic [15:0]              TTL_parallel,
  input  logic [15:0]              TTL_parallel_exp,
  input  logic [TS_W-1:0]          timestamp,
  input  logic [TTL_W-1:0]         rise_mask,
  input  logic [TTL_W-1:0]         fall_mask,
  input  logic                     clear_overflow,
  output logic [TTL_W-1:0]         ttl_stable,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_timestamp,
  output logic [TTL_W-1:0]         evt_rise,
  output logic [TTL_W-1:0]         evt_fall,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  // ---------------------------------------------------------------------------
  // Stage 1: capture on the sample strobe
  // ---------------------------------------------------------------------------
  logic             strobe;
  logic [TTL_W-1:0] raw_q, rmask_q, fmask_q;
  logic [TS_W-1:0]  ts_q;
  logic             s2_valid_q;

  assign strobe = enable && (main_state == MS_CLK11_A) && (channel == SAMPLE_CHANNEL);

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q      <= '0;
      ts_q       <= '0;
      rmask_q    <= '0;
      fmask_q    <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= strobe;
      if (strobe) begin
        raw_q   <= {TTL_parallel_exp, TTL_parallel};
        ts_q    <= timestamp;
        rmask_q <= rise_mask;
        fmask_q <= fall_mask;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: debounce and edge detection
  // ---------------------------------------------------------------------------
  logic [TTL_W-1:0]      stable_q, stable_d;
  logic [TTL_W-1:0][3:0] cnt_q, cnt_d;
  logic                  primed_q, primed_d;
  logic [TTL_W-1:0]      edges, rise, fall;
  logic [4:0]            thr;

  assign thr = debounce_threshold(debounce_samples);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    edges    = '0;
    if (!enable) begin
      // Disabled: forget history so the next strobe re-primes without edges.
      primed_d = 1'b0;
      cnt_d    = '0;
    end else if (s2_valid_q) begin
      if (!primed_q) begin
        stable_d = raw_q;
        cnt_d    = '0;
        primed_d = 1'b1;
      end else begin
        for (int i = 0; i < TTL_W; i++) begin
          if (raw_q[i] == stable_q[i]) begin
            cnt_d[i] = 4'd0;
          end else if (({1'b0, cnt_q[i]} + 5'd1) >= thr) begin
            stable_d[i] = raw_q[i];
            cnt_d[i]    = 4'd0;
            edges[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end
      end
    end
  end

  // Masked-off edges still move ttl_stable; masks only gate what is recorded.
  assign rise = edges & raw_q & rmask_q;
  assign fall = edges & ~raw_q & fmask_q;

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO and overflow accounting
  // ---------------------------------------------------------------------------
  logic             push, pop, drop, fifo_full, fifo_empty;
  logic [REC_W-1:0] push_rec, head_rec;

  assign push = (rise | fall) != '0;

  always_comb begin
    push_rec = '0;
    push_rec[TS_LSB   +: TS_W]  = ts_q;
    push_rec[RISE_LSB +: TTL_W] = rise;
    push_rec[FALL_LSB +: TTL_W] = fall;
  end

  event_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_event_fifo (
    .clk_i   (dataclk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .head_o  (head_rec),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid     = !fifo_empty;
  assign pop           = evt_valid && evt_ready;
  assign drop          = push && fifo_full && !pop;
  assign evt_timestamp = head_rec[TS_LSB   +: TS_W];
  assign evt_rise      = head_rec[RISE_LSB +: TTL_W];
  assign evt_fall      = head_rec[FALL_LSB +: TTL_W];
  assign ttl_stable    = stable_q;

  logic        overflow_q;
  logic [15:0] drop_count_q;

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      // A drop coinciding with a clear counts as the first drop after clearing.
      overflow_q <= 1'b1;
      if (clear_overflow)                drop_count_q <= 16'd1;
      else if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end else if (clear_overflow) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
